multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the MIPS core. Sequences a shared ALU/memory datapath through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_ctrl_fsm.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS sequencer: walks the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with memory and mul/div, and traps on
// an illegal opcode or a stalled handshake.
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_done,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_start,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       trap,
    output logic [1:0] trap_cause
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          st, st_nx, done_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            trap_q, trap_nx;
    logic [1:0]      cause_q, cause_nx, wait_cause;
    logic            wait_act, wait_done;
    logic            mem_req_c, mem_we_c, ir_write_c, pc_write_c, alu_start_c, reg_write_c;
    logic [1:0]      pc_src_c, wb_sel_c;

    // Opcode classes
    logic is_r, is_lw, is_sw, is_imm, is_md, is_br, is_j, is_jal, legal;
    assign is_r   = (opcode == 6'b000000);
    assign is_lw  = (opcode == 6'b000100);
    assign is_sw  = (opcode == 6'b000101);
    assign is_imm = (opcode == 6'b000001) || (opcode == 6'b000111);
    assign is_md  = (opcode == 6'b001111) || (opcode == 6'b010000);
    assign is_br  = (opcode == 6'b000110) || (opcode >= 6'b001000 && opcode <= 6'b001100);
    assign is_j   = (opcode == 6'b001101);
    assign is_jal = (opcode == 6'b001110);
    assign legal  = is_r | is_lw | is_sw | is_imm | is_md | is_br | is_j | is_jal;

    // Next-state, wait-counter and control decode from the registered state
    always_comb begin
        st_nx       = st;
        cnt_nx      = cnt;
        trap_nx     = trap_q;
        cause_nx    = cause_q;
        done_nx     = st;
        wait_act    = 1'b0;
        wait_done   = 1'b0;
        wait_cause  = 2'b00;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 2'b00;
        alu_start_c = 1'b0;
        reg_write_c = 1'b0;
        wb_sel_c    = 2'b00;
        case (st)
            S_FETCH: begin
                if (run) begin
                    mem_req_c  = 1'b1;
                    wait_act   = 1'b1;
                    wait_done  = mem_ready;
                    wait_cause = 2'b10;
                    done_nx    = S_DECODE;
                    ir_write_c = mem_ready;
                    pc_write_c = mem_ready;
                end else begin
                    // halted on an instruction boundary: not a handshake wait
                    cnt_nx = '0;
                end
            end
            S_DECODE: begin
                if (legal) st_nx = S_EXEC;
                else begin
                    st_nx    = S_TRAP;
                    trap_nx  = 1'b1;
                    cause_nx = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_md) begin
                    // counter is cleared on entry, so zero marks the first EXEC cycle
                    alu_start_c = (cnt == '0);
                    wait_act    = 1'b1;
                    wait_done   = alu_done;
                    wait_cause  = 2'b11;
                    done_nx     = S_WB;
                end else if (is_lw || is_sw) st_nx = S_MEM;
                else if (is_r || is_imm) st_nx = S_WB;
                else if (is_br) begin
                    pc_write_c = branch_taken;
                    pc_src_c   = 2'b01;
                    st_nx      = S_FETCH;
                end else begin
                    pc_write_c  = is_j | is_jal;
                    pc_src_c    = 2'b10;
                    reg_write_c = is_jal;
                    wb_sel_c    = is_jal ? 2'b10 : 2'b00;
                    st_nx       = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                mem_we_c   = is_sw;
                wait_act   = 1'b1;
                wait_done  = mem_ready;
                wait_cause = 2'b10;
                done_nx    = is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write_c = 1'b1;
                wb_sel_c    = is_lw ? 2'b01 : 2'b00;
                st_nx       = S_FETCH;
            end
            S_TRAP:  st_nx = S_TRAP;
            default: st_nx = S_FETCH;
        endcase
        // completion in the last allowed cycle beats the timeout
        if (wait_act) begin
            if (wait_done) st_nx = done_nx;
            else if (cnt == CW'(TIMEOUT - 1)) begin
                st_nx    = S_TRAP;
                trap_nx  = 1'b1;
                cause_nx = wait_cause;
            end else cnt_nx = cnt + 1'b1;
        end
        if (st_nx != st) cnt_nx = '0;
    end

    // State, wait counter and sticky trap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= S_FETCH;
            cnt     <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            st      <= st_nx;
            cnt     <= cnt_nx;
            trap_q  <= trap_nx;
            cause_q <= cause_nx;
        end
    end

    // Reset masks the combinational enables so an aborted access never writes
    assign mem_req    = !rst && mem_req_c;
    assign mem_we     = !rst && mem_we_c;
    assign ir_write   = !rst && ir_write_c;
    assign pc_write   = !rst && pc_write_c;
    assign pc_src     = rst ? 2'b00 : pc_src_c;
    assign alu_start  = !rst && alu_start_c;
    assign reg_write  = !rst && reg_write_c;
    assign wb_sel     = rst ? 2'b00 : wb_sel_c;
    assign state      = rst ? 3'd0 : st;
    assign trap       = !rst && trap_q;
    assign trap_cause = rst ? 2'b00 : cause_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed literal checks plus a randomized
// run compared every cycle against a behavioural model of the sequencer.
module tb_multicycle_ctrl_fsm;
    localparam int TO = 8;
    localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_MD = 4, K_BR = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

    logic clk = 1'b0, rst = 1'b1, run = 1'b0, mem_ready = 1'b0, alu_done = 1'b0, branch_taken = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic mem_req, mem_we, ir_write, pc_write, alu_start, reg_write, trap;
    logic [1:0] pc_src, wb_sel, trap_cause;
    logic [2:0] state;
    int n_tests = 0, n_fail = 0;

    multicycle_ctrl_fsm #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .alu_done(alu_done), .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_start(alu_start),
        .reg_write(reg_write), .wb_sel(wb_sel), .state(state), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'd0:                             return K_R;
            6'd1, 6'd7:                       return K_IMM;
            6'd4:                             return K_LW;
            6'd5:                             return K_SW;
            6'd15, 6'd16:                     return K_MD;
            6'd6, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: return K_BR;
            6'd13:                            return K_J;
            6'd14:                            return K_JAL;
            default:                          return K_ILL;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // phase numbers are the architectural state codes; wt_n = consecutive unmet wait cycles
    int m_ph = 0, m_wt = 0, m_cause = 0, n_ph = 0, n_wt = 0, n_cause = 0;
    bit m_trap = 0, n_trap = 0;

    always @(negedge clk) begin
        int c, e_state, e_cause, dph, wc;
        bit e_mr, e_we, e_ir, e_pw, e_as, e_rw, e_trap, waits, dn;
        int e_ps, e_wb;
        c = cls(opcode);
        {e_mr, e_we, e_ir, e_pw, e_as, e_rw} = '0;
        e_ps = 0; e_wb = 0; waits = 0; dn = 0; dph = 0; wc = 0;
        n_ph = m_ph; n_wt = m_wt; n_trap = m_trap; n_cause = m_cause;
        if (rst) begin
            e_state = 0; e_trap = 0; e_cause = 0;
            n_ph = 0; n_wt = 0; n_trap = 0; n_cause = 0;
        end else begin
            e_state = m_ph; e_trap = m_trap; e_cause = m_cause;
            case (m_ph)
                0: if (run) begin
                       e_mr = 1; waits = 1; dn = mem_ready; dph = 1; wc = 2;
                       if (mem_ready) begin e_ir = 1; e_pw = 1; end
                   end else n_wt = 0;
                1: if (c == K_ILL) begin n_ph = 5; n_trap = 1; n_cause = 1; end else n_ph = 2;
                2: case (c)
                       K_MD:  begin e_as = (m_wt == 0); waits = 1; dn = alu_done; dph = 4; wc = 3; end
                       K_LW, K_SW: n_ph = 3;
                       K_R, K_IMM: n_ph = 4;
                       K_BR:  begin e_pw = branch_taken; e_ps = 1; n_ph = 0; end
                       K_J:   begin e_pw = 1; e_ps = 2; n_ph = 0; end
                       default: begin e_pw = 1; e_ps = 2; e_rw = 1; e_wb = 2; n_ph = 0; end
                   endcase
                3: begin
                       e_mr = 1; e_we = (c == K_SW); waits = 1; dn = mem_ready; wc = 2;
                       dph = (c == K_LW) ? 4 : 0;
                   end
                4: begin e_rw = 1; e_wb = (c == K_LW) ? 1 : 0; n_ph = 0; end
                default: ;
            endcase
            if (waits) begin
                if (dn) n_ph = dph;
                else if (m_wt + 1 >= TO) begin n_ph = 5; n_trap = 1; n_cause = wc; end
                else n_wt = m_wt + 1;
            end
            if (n_ph != m_ph) n_wt = 0;
        end
        chk("m_state", 8'(state), 8'(e_state));
        chk("m_mem_req", 8'(mem_req), 8'(e_mr));
        chk("m_mem_we", 8'(mem_we), 8'(e_we));
        chk("m_ir_write", 8'(ir_write), 8'(e_ir));
        chk("m_pc_write", 8'(pc_write), 8'(e_pw));
        chk("m_pc_src", 8'(pc_src), 8'(e_ps));
        chk("m_alu_start", 8'(alu_start), 8'(e_as));
        chk("m_reg_write", 8'(reg_write), 8'(e_rw));
        chk("m_wb_sel", 8'(wb_sel), 8'(e_wb));
        chk("m_trap", 8'(trap), 8'(e_trap));
        chk("m_trap_cause", 8'(trap_cause), 8'(e_cause));
    end

    always @(posedge clk) begin
        m_ph <= n_ph; m_wt <= n_wt; m_trap <= n_trap; m_cause <= n_cause;
    end

    // ---------------- directed helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask
    task automatic at_neg();
        @(negedge clk);
    endtask
    // assumes FETCH with run=0; fetches op with zero wait, leaves DUT in DECODE
    task automatic fetch(input logic [5:0] op);
        cyc(); run = 1; mem_ready = 1; opcode = op;
        at_neg(); chk("fetch_state", 8'(state), 8'd0); chk("fetch_ir", 8'(ir_write), 8'd1);
        chk("fetch_pcw", 8'(pc_write), 8'd1); chk("fetch_pcsrc", 8'(pc_src), 8'd0);
        cyc(); run = 0; mem_ready = 0;
        at_neg(); chk("decode_state", 8'(state), 8'd1);
    endtask
    task automatic reset_pulse();
        cyc(); rst = 1; mem_ready = 0; alu_done = 0;
        at_neg(); chk("rst_state", 8'(state), 8'd0); chk("rst_trap", 8'(trap), 8'd0);
        chk("rst_cause", 8'(trap_cause), 8'd0); chk("rst_memreq", 8'(mem_req), 8'd0);
        cyc(); rst = 0;
    endtask

    initial begin
        int cnt;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // reset state
        at_neg(); chk("rst_state0", 8'(state), 8'd0); chk("rst_memreq0", 8'(mem_req), 8'd0);
        chk("rst_trap0", 8'(trap), 8'd0);
        cyc(); rst = 0;
        // halted fetch
        for (int i = 0; i < 3; i++) begin
            cyc(); at_neg(); chk("halt_memreq", 8'(mem_req), 8'd0); chk("halt_state", 8'(state), 8'd0);
        end
        // R-type: 0,1,2,4,0
        fetch(6'd0);
        cyc(); at_neg(); chk("r_exec", 8'(state), 8'd2); chk("r_exec_rw", 8'(reg_write), 8'd0);
        chk("r_exec_pcw", 8'(pc_write), 8'd0);
        cyc(); at_neg(); chk("r_wb", 8'(state), 8'd4); chk("r_wb_rw", 8'(reg_write), 8'd1);
        chk("r_wb_sel", 8'(wb_sel), 8'd0);
        cyc(); at_neg(); chk("r_back", 8'(state), 8'd0);
        // LW, 3 wait cycles in MEM
        fetch(6'd4);
        cyc(); at_neg(); chk("lw_exec", 8'(state), 8'd2);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(); mem_ready = (i == 3);
            at_neg(); if (state == 3'd3 && mem_req && !mem_we) cnt++;
        end
        chk("lw_memreq_cycles", 8'(cnt), 8'd4);
        cyc(); mem_ready = 0; at_neg(); chk("lw_wb", 8'(state), 8'd4); chk("lw_wbsel", 8'(wb_sel), 8'd1);
        chk("lw_rw", 8'(reg_write), 8'd1);
        cyc(); at_neg(); chk("lw_back", 8'(state), 8'd0);
        // SW
        fetch(6'd5);
        cyc(); at_neg(); chk("sw_exec", 8'(state), 8'd2);
        cyc(); mem_ready = 1; at_neg(); chk("sw_mem", 8'(state), 8'd3); chk("sw_we", 8'(mem_we), 8'd1);
        cyc(); mem_ready = 0; at_neg(); chk("sw_nowb", 8'(state), 8'd0); chk("sw_rw", 8'(reg_write), 8'd0);
        // branches
        fetch(6'd6);
        cyc(); branch_taken = 1; at_neg(); chk("bt_pcw", 8'(pc_write), 8'd1); chk("bt_src", 8'(pc_src), 8'd1);
        cyc(); at_neg(); chk("bt_back", 8'(state), 8'd0);
        fetch(6'd6);
        cyc(); branch_taken = 0; at_neg(); chk("bn_pcw", 8'(pc_write), 8'd0);
        cyc(); at_neg(); chk("bn_back", 8'(state), 8'd0);
        fetch(6'd14);
        cyc(); at_neg(); chk("jal_pcw", 8'(pc_write), 8'd1); chk("jal_rw", 8'(reg_write), 8'd1);
        chk("jal_wbsel", 8'(wb_sel), 8'd2); chk("jal_src", 8'(pc_src), 8'd2);
        cyc(); at_neg(); chk("jal_back", 8'(state), 8'd0);
        // MULDIV, alu_done 5 cycles after start
        fetch(6'd15);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); alu_done = (i == 5); at_neg(); cnt += int'(alu_start);
            chk("md_exec", 8'(state), 8'd2);
        end
        chk("md_start_once", 8'(cnt), 8'd1);
        cyc(); alu_done = 0; at_neg(); chk("md_wb", 8'(state), 8'd4);
        cyc(); at_neg(); chk("md_back", 8'(state), 8'd0);
        // MULDIV completing in the TIMEOUT-th cycle wins
        fetch(6'd16);
        for (int i = 0; i < TO; i++) begin cyc(); alu_done = (i == TO - 1); at_neg(); end
        cyc(); alu_done = 0; at_neg(); chk("md_last_wins", 8'(state), 8'd4);
        cyc(); at_neg(); chk("md_last_back", 8'(state), 8'd0);
        // MULDIV timeout
        fetch(6'd16);
        cnt = 0;
        for (int i = 0; i < TO; i++) begin cyc(); at_neg(); if (state == 3'd2) cnt++; end
        chk("md_to_cycles", 8'(cnt), 8'(TO));
        cyc(); at_neg(); chk("md_to_state", 8'(state), 8'd5); chk("md_to_trap", 8'(trap), 8'd1);
        chk("md_to_cause", 8'(trap_cause), 8'd3);
        reset_pulse();
        // MEM timeout on LW
        fetch(6'd4);
        cyc(); at_neg();
        for (int i = 0; i < TO; i++) begin cyc(); at_neg(); end
        cyc(); at_neg(); chk("mem_to_state", 8'(state), 8'd5); chk("mem_to_cause", 8'(trap_cause), 8'd2);
        reset_pulse();
        // illegal opcode, sticky trap
        fetch(6'd63);
        cyc(); at_neg(); chk("ill_state", 8'(state), 8'd5); chk("ill_cause", 8'(trap_cause), 8'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(); mem_ready = i[0]; at_neg(); chk("ill_sticky", 8'(trap), 8'd1); chk("ill_hold", 8'(state), 8'd5);
            chk("ill_noreq", 8'(mem_req), 8'd0);
        end
        reset_pulse();
        // reset during the MEM cycle of a SW
        fetch(6'd5);
        cyc(); at_neg();
        cyc(); at_neg(); chk("swr_we", 8'(mem_we), 8'd1);
        cyc(); rst = 1; at_neg(); chk("swr_we_drop", 8'(mem_we), 8'd0); chk("swr_req_drop", 8'(mem_req), 8'd0);
        chk("swr_state", 8'(state), 8'd0);
        cyc(); rst = 0; at_neg(); chk("swr_after", 8'(state), 8'd0);

        // ---------------- randomized run ----------------
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (rst) rst = 0;
            else if (m_trap && ($urandom % 4 == 0)) rst = 1;
            else if ($urandom % 300 == 0) rst = 1;
            run = ($urandom % 8) != 0;
            mem_ready = ($urandom % 3) == 0;
            alu_done = ($urandom % 4) == 0;
            branch_taken = $urandom % 2;
            if (m_ph == 0) begin
                if ($urandom % 10 == 0) opcode = 6'($urandom);
                else begin
                    case ($urandom % 15)
                        0: opcode = 6'd0;   1: opcode = 6'd1;   2: opcode = 6'd4;
                        3: opcode = 6'd5;   4: opcode = 6'd7;   5: opcode = 6'd15;
                        6: opcode = 6'd16;  7: opcode = 6'd6;   8: opcode = 6'd8;
                        9: opcode = 6'd10;  10: opcode = 6'd12; 11: opcode = 6'd13;
                        12: opcode = 6'd14; 13: opcode = 6'd9;  default: opcode = 6'd11;
                    endcase
                end
            end
        end
        cyc(); at_neg();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
